// File: rtl/bmu_pkg.sv
// Shared constants and FSM encoding for the BMU row scheduler.
package bmu_pkg;

    localparam int unsigned DW   = 11;
    localparam int unsigned WW   = 24;
    localparam int unsigned NROW = 8;
    localparam int unsigned NCOL = 8;
    localparam int unsigned RW   = $clog2(NROW);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/bmu_row_scheduler_min8_tree.sv
// Combinational 3-level tournament picking the smallest distance in one row.
// On equal distances the left (lower-column) contender always wins.
module min8_tree
    import bmu_pkg::*;
(
    input  logic [NCOL*DW-1:0] d_row,
    input  logic [NCOL*WW-1:0] w_row,
    output logic [DW-1:0]      row_min_d,
    output logic [WW-1:0]      row_min_w,
    output logic [2:0]         row_min_col
);

    logic [DW-1:0] w_l1_d [4];
    logic [WW-1:0] w_l1_w [4];
    logic [2:0]    w_l1_c [4];
    logic [DW-1:0] w_l2_d [2];
    logic [WW-1:0] w_l2_w [2];
    logic [2:0]    w_l2_c [2];

    // Three tournament levels; left side wins ties so lower columns win
    always_comb begin
        for (int unsigned i = 0; i < 4; i++) begin
            if (d_row[(2*i)*DW +: DW] <= d_row[(2*i+1)*DW +: DW]) begin
                w_l1_d[i] = d_row[(2*i)*DW +: DW];
                w_l1_w[i] = w_row[(2*i)*WW +: WW];
                w_l1_c[i] = 3'(2*i);
            end else begin
                w_l1_d[i] = d_row[(2*i+1)*DW +: DW];
                w_l1_w[i] = w_row[(2*i+1)*WW +: WW];
                w_l1_c[i] = 3'(2*i+1);
            end
        end
        for (int unsigned j = 0; j < 2; j++) begin
            if (w_l1_d[2*j] <= w_l1_d[2*j+1]) begin
                w_l2_d[j] = w_l1_d[2*j];
                w_l2_w[j] = w_l1_w[2*j];
                w_l2_c[j] = w_l1_c[2*j];
            end else begin
                w_l2_d[j] = w_l1_d[2*j+1];
                w_l2_w[j] = w_l1_w[2*j+1];
                w_l2_c[j] = w_l1_c[2*j+1];
            end
        end
        if (w_l2_d[0] <= w_l2_d[1]) begin
            row_min_d   = w_l2_d[0];
            row_min_w   = w_l2_w[0];
            row_min_col = w_l2_c[0];
        end else begin
            row_min_d   = w_l2_d[1];
            row_min_w   = w_l2_w[1];
            row_min_col = w_l2_c[1];
        end
    end

endmodule

// File: rtl/bmu_row_scheduler.sv
// BMU search sequencer: issues 8 row reads, reduces returned rows to a row
// minimum and tracks the running best across rows (earlier row wins ties).
module bmu_row_scheduler
    import bmu_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    output logic               busy,
    output logic               rd_en,
    output logic [RW-1:0]      rd_row,
    input  logic               in_valid,
    input  logic [NCOL*DW-1:0] d_row,
    input  logic [NCOL*WW-1:0] w_row,
    output logic [2:0]         X_c,
    output logic [RW-1:0]      Y_c,
    output logic [WW-1:0]      weight_c,
    output logic [DW-1:0]      min_d,
    output logic               done
);

    state_t        r_state;
    logic [RW-1:0] r_issue_cnt;
    logic          r_issue_done;
    logic [RW-1:0] r_ret_cnt;
    logic [DW-1:0] r_best_d;
    logic [WW-1:0] r_best_w;
    logic [2:0]    r_best_x;
    logic [RW-1:0] r_best_y;
    logic [2:0]    r_x;
    logic [RW-1:0] r_y;
    logic [WW-1:0] r_w;
    logic [DW-1:0] r_d;

    logic [DW-1:0] w_row_min_d;
    logic [WW-1:0] w_row_min_w;
    logic [2:0]    w_row_min_col;
    logic          w_accept;
    logic          w_take;
    logic          w_last;
    logic [DW-1:0] w_nxt_d;
    logic [WW-1:0] w_nxt_w;
    logic [2:0]    w_nxt_x;
    logic [RW-1:0] w_nxt_y;

    min8_tree u_min8 (
        .d_row       (d_row),
        .w_row       (w_row),
        .row_min_d   (w_row_min_d),
        .row_min_w   (w_row_min_w),
        .row_min_col (w_row_min_col)
    );

    // Next-best selection; row 0 loads unconditionally, later rows need strictly less
    always_comb begin
        w_accept = (r_state == S_RUN) && in_valid;
        w_take   = w_accept && ((r_ret_cnt == '0) || (w_row_min_d < r_best_d));
        w_last   = w_accept && (r_ret_cnt == RW'(NROW-1));
        w_nxt_d  = r_best_d;
        w_nxt_w  = r_best_w;
        w_nxt_x  = r_best_x;
        w_nxt_y  = r_best_y;
        if (w_take) begin
            w_nxt_d = w_row_min_d;
            w_nxt_w = w_row_min_w;
            w_nxt_x = w_row_min_col;
            w_nxt_y = r_ret_cnt;
        end
    end

    // FSM, issue/return counters, running best and published result registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_issue_cnt  <= '0;
            r_issue_done <= 1'b0;
            r_ret_cnt    <= '0;
            r_best_d     <= '1;
            r_best_w     <= '0;
            r_best_x     <= '0;
            r_best_y     <= '0;
            r_x          <= '0;
            r_y          <= '0;
            r_w          <= '0;
            r_d          <= '1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state      <= S_RUN;
                        r_issue_cnt  <= '0;
                        r_issue_done <= 1'b0;
                        r_ret_cnt    <= '0;
                        r_best_d     <= '1;
                    end
                end
                S_RUN: begin
                    if (!r_issue_done) begin
                        r_issue_cnt <= r_issue_cnt + RW'(1);
                        if (r_issue_cnt == RW'(NROW-1)) begin
                            r_issue_done <= 1'b1;
                        end
                    end
                    if (w_accept) begin
                        r_ret_cnt <= r_ret_cnt + RW'(1);
                        r_best_d  <= w_nxt_d;
                        r_best_w  <= w_nxt_w;
                        r_best_x  <= w_nxt_x;
                        r_best_y  <= w_nxt_y;
                        // Results published on FIN entry include the 8th row's update
                        if (w_last) begin
                            r_state <= S_FIN;
                            r_x     <= w_nxt_x;
                            r_y     <= w_nxt_y;
                            r_w     <= w_nxt_w;
                            r_d     <= w_nxt_d;
                        end
                    end
                end
                S_FIN: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Outputs decoded from registered state
    always_comb begin
        busy     = (r_state != S_IDLE);
        done     = (r_state == S_FIN);
        rd_en    = (r_state == S_RUN) && !r_issue_done;
        rd_row   = r_issue_cnt;
        X_c      = r_x;
        Y_c      = r_y;
        weight_c = r_w;
        min_d    = r_d;
    end

endmodule

// File: tb/tb_bmu_row_scheduler.sv
// Directed bench for bmu_row_scheduler with a behavioural distance stage.
module tb_bmu_row_scheduler;
    import bmu_pkg::*;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic               busy;
    logic               rd_en;
    logic [RW-1:0]      rd_row;
    logic               in_valid = 1'b0;
    logic [NCOL*DW-1:0] d_row = '0;
    logic [NCOL*WW-1:0] w_row = '0;
    logic [2:0]         X_c;
    logic [RW-1:0]      Y_c;
    logic [WW-1:0]      weight_c;
    logic [DW-1:0]      min_d;
    logic               done;

    logic [DW-1:0] dm [8][8];
    logic [WW-1:0] wm [8][8];

    int n_chk = 0;
    int n_err = 0;

    bmu_row_scheduler dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .rd_en    (rd_en),
        .rd_row   (rd_row),
        .in_valid (in_valid),
        .d_row    (d_row),
        .w_row    (w_row),
        .X_c      (X_c),
        .Y_c      (Y_c),
        .weight_c (weight_c),
        .min_d    (min_d),
        .done     (done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic fill(input logic [DW-1:0] base);
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                dm[r][c] = base;
                wm[r][c] = 24'(32'h5A0000 + r * 16 + c);
            end
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_busy"},   32'(busy),     32'd0);
        check({tag, "_done"},   32'(done),     32'd0);
        check({tag, "_rden"},   32'(rd_en),    32'd0);
        check({tag, "_rdrow"},  32'(rd_row),   32'd0);
        check({tag, "_mind"},   32'(min_d),    32'h7FF);
        check({tag, "_x"},      32'(X_c),      32'd0);
        check({tag, "_y"},      32'(Y_c),      32'd0);
        check({tag, "_weight"}, 32'(weight_c), 32'd0);
    endtask

    // One search: lat = cycles from request to data, gaps inserts an idle
    // cycle after each returned row, poke pulses start mid-search, and
    // abort_after > 0 pulls rst low once that many rows were returned.
    task automatic run_search(input int lat, input bit gaps, input bit poke,
                              input int abort_after, input int ex, input int ey,
                              input int ed);
        int q_row[$];
        int q_rdy[$];
        int nrd = 0;
        int nret = 0;
        int ndone = 0;
        int done_cyc = 0;
        int r;
        bit skip = 0;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            if (cyc > 0) @(negedge clk);
            in_valid = 1'b0;
            start = poke && (cyc == 2 || cyc == 3);
            if (cyc == 0) check("busy_on", 32'(busy), 32'd1);
            if (abort_after > 0 && nret == abort_after) begin
                check("abort_nodone", 32'(done), 32'd0);
                rst = 1'b0;
                @(negedge clk);
                rst = 1'b1;
                check_reset_vals("abort");
                for (int k = 0; k < 12; k++) begin
                    @(negedge clk);
                    if (done) check("abort_spurious_done", 32'(done), 32'd0);
                end
                check("abort_idle", 32'(busy), 32'd0);
                return;
            end
            if (rd_en) begin
                check($sformatf("rd_row%0d", nrd), 32'(rd_row), 32'(nrd));
                q_row.push_back(int'(rd_row));
                q_rdy.push_back(cyc + lat);
                nrd++;
            end
            if (done) begin
                ndone++;
                if (ndone == 1) begin
                    done_cyc = cyc;
                    check("X_c",      32'(X_c),      32'(ex));
                    check("Y_c",      32'(Y_c),      32'(ey));
                    check("min_d",    32'(min_d),    32'(ed));
                    check("weight_c", 32'(weight_c), 32'(wm[ey][ex]));
                    check("rd_cycles", 32'(nrd),     32'd8);
                    check("busy_fin", 32'(busy),     32'd1);
                end
            end
            if (!skip && q_row.size() > 0 && q_rdy[0] <= cyc) begin
                r = q_row.pop_front();
                void'(q_rdy.pop_front());
                for (int c = 0; c < 8; c++) begin
                    d_row[c*DW +: DW] = dm[r][c];
                    w_row[c*WW +: WW] = wm[r][c];
                end
                in_valid = 1'b1;
                nret++;
                skip = gaps;
            end else begin
                skip = 1'b0;
            end
            if (ndone > 0 && cyc >= done_cyc + 4) break;
        end
        in_valid = 1'b0;
        start = 1'b0;
        check("done_count", 32'(ndone), 32'd1);
        check("busy_off",   32'(busy),  32'd0);
    endtask

    initial begin
        // Reset held two cycles
        rst = 1'b0;
        fill(11'd0);
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst = 1'b1;

        // Single minimum, 1-cycle latency
        fill(11'd500);
        dm[5][3] = 11'd17;
        run_search(1, 1'b0, 1'b0, 0, 3, 5, 17);

        // Ties within a row and across rows
        fill(11'd100);
        dm[2][6] = 11'd9;
        dm[2][1] = 11'd9;
        dm[6][0] = 11'd9;
        run_search(1, 1'b0, 1'b0, 0, 1, 2, 9);

        // Latency 3 with gaps, minimum in the last cell
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                dm[r][c] = 11'(50 + r + c);
                wm[r][c] = 24'(32'h5A0000 + r * 16 + c);
            end
        end
        dm[7][7] = 11'd0;
        run_search(3, 1'b1, 1'b0, 0, 7, 7, 0);

        // All distances at maximum: first cell wins
        fill(11'h7FF);
        run_search(2, 1'b0, 1'b0, 0, 0, 0, 32'h7FF);

        // Start while busy, then stray in_valid while idle
        fill(11'd200);
        dm[4][2] = 11'd3;
        run_search(2, 1'b0, 1'b1, 0, 2, 4, 3);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            d_row = '0;
            w_row = '1;
            in_valid = 1'b1;
            @(negedge clk);
            in_valid = 1'b0;
            check("stray_nodone", 32'(done), 32'd0);
            check("stray_idle",   32'(busy), 32'd0);
        end
        check("hold_x",      32'(X_c),      32'd2);
        check("hold_y",      32'(Y_c),      32'd4);
        check("hold_mind",   32'(min_d),    32'd3);
        check("hold_weight", 32'(weight_c), 32'(wm[4][2]));

        // Abort after five rows, then a fresh search
        fill(11'd300);
        dm[1][1] = 11'd5;
        run_search(1, 1'b1, 1'b0, 5, 1, 1, 5);
        fill(11'd80);
        dm[3][6] = 11'd1;
        run_search(1, 1'b0, 1'b0, 0, 6, 3, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
